// File: rtl/logic_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : logic_bus_arb
// Purpose  : Two-master round-robin arbiter for a four-phase shared logic bus,
//            with a stall timeout and a saturating error counter.
// Revision : 1.0
// ============================================================================
module logic_bus_arb #(
    parameter int P_TIMEOUT_CNT_MAX = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] m0_adr,
    input  logic [15:0] m0_wr_data,
    input  logic        m0_wr_req,
    input  logic        m0_rd_req,
    output logic        m0_ack,
    output logic [15:0] m0_rd_data,
    input  logic [11:0] m1_adr,
    input  logic [15:0] m1_wr_data,
    input  logic        m1_wr_req,
    input  logic        m1_rd_req,
    output logic        m1_ack,
    output logic [15:0] m1_rd_data,
    output logic [11:0] s_adr,
    output logic [15:0] s_wr_data,
    output logic        s_wr_req,
    output logic        s_rd_req,
    input  logic        s_ack,
    input  logic [15:0] s_rd_data,
    output logic        owner,
    output logic        err_timeout,
    output logic [7:0]  err_cnt
);

    localparam int c_CNT_W = $clog2(P_TIMEOUT_CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1
    } state_t;

    state_t              r_state;
    logic                r_owner;
    logic [11:0]         r_s_adr;
    logic [15:0]         r_s_wr_data;
    logic                r_s_wr_req;
    logic                r_s_rd_req;
    logic                r_gnt_rd;
    logic                r_ack_q;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_err_timeout;
    logic [7:0]          r_err_cnt;
    logic [15:0]         r_m0_rd_data;
    logic [15:0]         r_m1_rd_data;

    logic w_m0_req;
    logic w_m1_req;
    logic w_gnt_idx;
    logic w_new_wr;
    logic w_new_rd;
    logic w_sel_wr;
    logic w_sel_rd;
    logic w_ack_fall;
    logic w_timeout;

    assign w_m0_req = m0_wr_req | m0_rd_req;
    assign w_m1_req = m1_wr_req | m1_rd_req;

    // On a tie the master that did not own the bus last wins.
    always_comb begin
        w_gnt_idx = w_m1_req;
        if (w_m0_req && w_m1_req) begin
            w_gnt_idx = ~r_owner;
        end
    end

    // A write takes precedence over a simultaneous read from the same master.
    assign w_new_wr   = w_gnt_idx ? m1_wr_req : m0_wr_req;
    assign w_new_rd   = w_gnt_idx ? (m1_rd_req & ~m1_wr_req) : (m0_rd_req & ~m0_wr_req);
    assign w_sel_wr   = r_owner ? m1_wr_req : m0_wr_req;
    assign w_sel_rd   = r_owner ? (m1_rd_req & ~m1_wr_req) : (m0_rd_req & ~m0_wr_req);
    assign w_ack_fall = r_ack_q & ~s_ack;
    assign w_timeout  = (r_cnt == c_CNT_W'(P_TIMEOUT_CNT_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_owner       <= 1'b1;
            r_s_adr       <= '0;
            r_s_wr_data   <= '0;
            r_s_wr_req    <= 1'b0;
            r_s_rd_req    <= 1'b0;
            r_gnt_rd      <= 1'b0;
            r_ack_q       <= 1'b0;
            r_cnt         <= '0;
            r_err_timeout <= 1'b0;
            r_err_cnt     <= '0;
            r_m0_rd_data  <= '0;
            r_m1_rd_data  <= '0;
        end else begin
            r_err_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_s_wr_req <= 1'b0;
                    r_s_rd_req <= 1'b0;
                    r_cnt      <= '0;
                    r_ack_q    <= 1'b0;
                    if (w_m0_req || w_m1_req) begin
                        r_owner     <= w_gnt_idx;
                        r_s_adr     <= w_gnt_idx ? m1_adr : m0_adr;
                        r_s_wr_data <= w_gnt_idx ? m1_wr_data : m0_wr_data;
                        r_s_wr_req  <= w_new_wr;
                        r_s_rd_req  <= w_new_rd;
                        r_gnt_rd    <= w_new_rd;
                        r_state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_ack_q <= s_ack;
                    if (s_ack && r_gnt_rd) begin
                        if (r_owner) begin
                            r_m1_rd_data <= s_rd_data;
                        end else begin
                            r_m0_rd_data <= s_rd_data;
                        end
                    end
                    if (w_ack_fall) begin
                        r_s_wr_req <= 1'b0;
                        r_s_rd_req <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (w_timeout) begin
                        // Owner is left on the aborted master so the other one wins the next tie.
                        r_s_wr_req    <= 1'b0;
                        r_s_rd_req    <= 1'b0;
                        r_err_timeout <= 1'b1;
                        if (r_err_cnt != 8'hFF) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt      <= r_cnt + 1'b1;
                        r_s_wr_req <= w_sel_wr;
                        r_s_rd_req <= w_sel_rd;
                    end
                end
                default: begin
                    r_s_wr_req <= 1'b0;
                    r_s_rd_req <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign m0_ack      = s_ack & (r_state == S_BUSY) & ~r_owner;
    assign m1_ack      = s_ack & (r_state == S_BUSY) & r_owner;
    assign m0_rd_data  = r_m0_rd_data;
    assign m1_rd_data  = r_m1_rd_data;
    assign s_adr       = r_s_adr;
    assign s_wr_data   = r_s_wr_data;
    assign s_wr_req    = r_s_wr_req;
    assign s_rd_req    = r_s_rd_req;
    assign owner       = r_owner;
    assign err_timeout = r_err_timeout;
    assign err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_logic_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_bus_arb
// Purpose  : Self-checking bench for logic_bus_arb with a grant scoreboard.
// Revision : 1.0
// ============================================================================
module tb_logic_bus_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] m0_adr = '0, m1_adr = '0;
    logic [15:0] m0_wr_data = '0, m1_wr_data = '0;
    logic        m0_wr_req = 1'b0, m0_rd_req = 1'b0, m1_wr_req = 1'b0, m1_rd_req = 1'b0;
    logic        m0_ack, m1_ack;
    logic [15:0] m0_rd_data, m1_rd_data;
    logic [11:0] s_adr;
    logic [15:0] s_wr_data;
    logic        s_wr_req, s_rd_req;
    logic        s_ack = 1'b0;
    logic [15:0] s_rd_data = '0;
    logic        owner, err_timeout;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;

    // Grant record: {owner, s_adr, s_wr_data, s_wr_req, s_rd_req}
    logic [30:0] exp_q[$];

    always #5 clk = ~clk;

    logic_bus_arb #(.P_TIMEOUT_CNT_MAX(1000)) dut (
        .clk(clk), .rst(rst),
        .m0_adr(m0_adr), .m0_wr_data(m0_wr_data), .m0_wr_req(m0_wr_req), .m0_rd_req(m0_rd_req),
        .m0_ack(m0_ack), .m0_rd_data(m0_rd_data),
        .m1_adr(m1_adr), .m1_wr_data(m1_wr_data), .m1_wr_req(m1_wr_req), .m1_rd_req(m1_rd_req),
        .m1_ack(m1_ack), .m1_rd_data(m1_rd_data),
        .s_adr(s_adr), .s_wr_data(s_wr_data), .s_wr_req(s_wr_req), .s_rd_req(s_rd_req),
        .s_ack(s_ack), .s_rd_data(s_rd_data),
        .owner(owner), .err_timeout(err_timeout), .err_cnt(err_cnt)
    );

    task automatic master_set(input int m, input logic wr, input logic rd,
                              input logic [11:0] adr, input logic [15:0] wd);
        if (m == 0) begin
            m0_adr = adr; m0_wr_data = wd; m0_wr_req = wr; m0_rd_req = rd;
        end else begin
            m1_adr = adr; m1_wr_data = wd; m1_wr_req = wr; m1_rd_req = rd;
        end
        exp_q.push_back({m[0], adr, wd, wr, rd & ~wr});
    endtask

    // Slave acks, master drops its request, slave drops ack; ends with the arbiter idle.
    task automatic slave_serve(input int m, input logic [15:0] rdv);
        s_rd_data = rdv;
        s_ack = 1'b1;
        @(negedge clk);
        if (m == 0) begin m0_wr_req = 1'b0; m0_rd_req = 1'b0; end
        else        begin m1_wr_req = 1'b0; m1_rd_req = 1'b0; end
        @(negedge clk);
        s_ack = 1'b0;
        s_rd_data = '0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [30:0] got;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        got = {owner, s_adr, s_wr_data, s_wr_req, s_rd_req};
        total++;
        if (got !== {1'b1, 12'h000, 16'h0000, 1'b0, 1'b0}) begin
            bad++; $display("FAIL reset_bus got=%h exp=%h", got, {1'b1, 30'h0});
        end
        total++;
        if ({m0_ack, m1_ack, err_timeout, err_cnt, m0_rd_data, m1_rd_data} !== 43'h0) begin
            bad++; $display("FAIL reset_misc got=%h exp=0",
                            {m0_ack, m1_ack, err_timeout, err_cnt, m0_rd_data, m1_rd_data});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write;
        logic [30:0] exp;
        master_set(0, 1'b1, 1'b0, 12'h123, 16'hBEEF);
        total++;
        if (s_wr_req !== 1'b0) begin bad++; $display("FAIL wr_early got=%b exp=0", s_wr_req); end
        @(negedge clk);
        exp = exp_q.pop_front();
        total++;
        if ({owner, s_adr, s_wr_data, s_wr_req, s_rd_req} !== exp) begin
            bad++; $display("FAIL wr_grant got=%h exp=%h", {owner, s_adr, s_wr_data, s_wr_req, s_rd_req}, exp);
        end
        repeat (2) @(negedge clk);
        s_ack = 1'b1;
        #1;
        total++;
        if ({m0_ack, m1_ack} !== 2'b10) begin bad++; $display("FAIL wr_ack got=%b exp=10", {m0_ack, m1_ack}); end
        @(negedge clk);
        m0_wr_req = 1'b0;
        @(negedge clk);
        total++;
        if ({s_wr_req, m0_ack} !== 2'b01) begin
            bad++; $display("FAIL wr_req_drop got=%b exp=01", {s_wr_req, m0_ack});
        end
        s_ack = 1'b0;
        #1;
        total++;
        if (m0_ack !== 1'b0) begin bad++; $display("FAIL wr_ack_fall got=%b exp=0", m0_ack); end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_tie;
        logic [30:0] exp;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        master_set(0, 1'b1, 1'b0, 12'h200, 16'h1111);
        master_set(1, 1'b1, 1'b0, 12'h300, 16'h2222);
        @(negedge clk);
        exp = exp_q.pop_front();
        total++;
        if ({owner, s_adr, s_wr_data, s_wr_req, s_rd_req} !== exp) begin
            bad++; $display("FAIL tie_first got=%h exp=%h", {owner, s_adr, s_wr_data, s_wr_req, s_rd_req}, exp);
        end
        s_ack = 1'b1;
        #1;
        total++;
        if (m1_ack !== 1'b0) begin bad++; $display("FAIL tie_holdoff got=%b exp=0", m1_ack); end
        slave_serve(0, 16'h0000);
        @(negedge clk);
        exp = exp_q.pop_front();
        total++;
        if ({owner, s_adr, s_wr_data, s_wr_req, s_rd_req} !== exp) begin
            bad++; $display("FAIL tie_second got=%h exp=%h", {owner, s_adr, s_wr_data, s_wr_req, s_rd_req}, exp);
        end
        slave_serve(1, 16'h0000);
    endtask

    task automatic test_read;
        logic [30:0] exp;
        master_set(0, 1'b0, 1'b1, 12'h0AA, 16'h0000);
        @(negedge clk);
        exp = exp_q.pop_front();
        total++;
        if ({owner, s_adr, s_wr_data, s_wr_req, s_rd_req} !== exp) begin
            bad++; $display("FAIL rd0_grant got=%h exp=%h", {owner, s_adr, s_wr_data, s_wr_req, s_rd_req}, exp);
        end
        slave_serve(0, 16'h1234);
        master_set(1, 1'b0, 1'b1, 12'h010, 16'h0000);
        @(negedge clk);
        exp = exp_q.pop_front();
        total++;
        if ({owner, s_adr, s_wr_data, s_wr_req, s_rd_req} !== exp) begin
            bad++; $display("FAIL rd1_grant got=%h exp=%h", {owner, s_adr, s_wr_data, s_wr_req, s_rd_req}, exp);
        end
        s_rd_data = 16'h5A5A;
        s_ack = 1'b1;
        #1;
        total++;
        if ({m0_ack, m1_ack} !== 2'b01) begin bad++; $display("FAIL rd1_ack got=%b exp=01", {m0_ack, m1_ack}); end
        @(negedge clk);
        m1_rd_req = 1'b0;
        @(negedge clk);
        s_ack = 1'b0;
        s_rd_data = '0;
        @(negedge clk);
        total++;
        if ({m0_rd_data, m1_rd_data} !== {16'h1234, 16'h5A5A}) begin
            bad++; $display("FAIL rd_data got=%h exp=%h", {m0_rd_data, m1_rd_data}, {16'h1234, 16'h5A5A});
        end
    endtask

    task automatic test_both_req;
        logic [30:0] exp;
        master_set(0, 1'b1, 1'b1, 12'h055, 16'h7777);
        @(negedge clk);
        exp = exp_q.pop_front();
        total++;
        if ({owner, s_adr, s_wr_data, s_wr_req, s_rd_req} !== exp) begin
            bad++; $display("FAIL wr_rd_both got=%h exp=%h", {owner, s_adr, s_wr_data, s_wr_req, s_rd_req}, exp);
        end
        slave_serve(0, 16'h0000);
    endtask

    task automatic test_timeout;
        logic [30:0] exp;
        int   n    = 0;
        logic seen = 1'b0;
        master_set(0, 1'b0, 1'b1, 12'h0F0, 16'h0000);
        @(negedge clk);
        exp = exp_q.pop_front();
        total++;
        if ({owner, s_adr, s_wr_data, s_wr_req, s_rd_req} !== exp) begin
            bad++; $display("FAIL to_grant got=%h exp=%h", {owner, s_adr, s_wr_data, s_wr_req, s_rd_req}, exp);
        end
        master_set(1, 1'b1, 1'b0, 12'h3C3, 16'hA5A5);
        while (n < 1100 && !seen) begin
            @(negedge clk);
            n++;
            seen = err_timeout;
        end
        total++;
        if (!seen || n != 1000) begin bad++; $display("FAIL to_cycle got=%0d exp=1000", n); end
        total++;
        if ({s_rd_req, err_cnt} !== {1'b0, 8'd1}) begin
            bad++; $display("FAIL to_abort got=%h exp=%h", {s_rd_req, err_cnt}, {1'b0, 8'd1});
        end
        @(negedge clk);
        total++;
        if (err_timeout !== 1'b0) begin bad++; $display("FAIL to_pulse got=%b exp=0", err_timeout); end
        exp = exp_q.pop_front();
        total++;
        if ({owner, s_adr, s_wr_data, s_wr_req, s_rd_req} !== exp) begin
            bad++; $display("FAIL to_next got=%h exp=%h", {owner, s_adr, s_wr_data, s_wr_req, s_rd_req}, exp);
        end
        m0_rd_req = 1'b0;
        slave_serve(1, 16'h0000);
    endtask

    task automatic test_reset_mid;
        logic [30:0] exp;
        master_set(0, 1'b1, 1'b0, 12'h0FF, 16'h4242);
        @(negedge clk);
        exp = exp_q.pop_front();
        total++;
        if ({owner, s_adr, s_wr_data, s_wr_req, s_rd_req} !== exp) begin
            bad++; $display("FAIL rm_grant got=%h exp=%h", {owner, s_adr, s_wr_data, s_wr_req, s_rd_req}, exp);
        end
        s_ack = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({owner, s_adr, s_wr_data, s_wr_req, s_rd_req, m0_ack, m1_ack, err_timeout, err_cnt,
             m0_rd_data, m1_rd_data} !== {1'b1, 73'h0}) begin
            bad++; $display("FAIL rm_reset got=%h exp=%h", {owner, s_adr, s_wr_data, s_wr_req, s_rd_req,
                            m0_ack, m1_ack, err_timeout, err_cnt, m0_rd_data, m1_rd_data}, {1'b1, 73'h0});
        end
        rst = 1'b0;
        m0_wr_req = 1'b0;
        s_ack = 1'b0;
        @(negedge clk);
        master_set(1, 1'b0, 1'b1, 12'h010, 16'h0000);
        @(negedge clk);
        exp = exp_q.pop_front();
        total++;
        if ({owner, s_adr, s_wr_data, s_wr_req, s_rd_req} !== exp) begin
            bad++; $display("FAIL rm_fresh got=%h exp=%h", {owner, s_adr, s_wr_data, s_wr_req, s_rd_req}, exp);
        end
        slave_serve(1, 16'hC0DE);
        total++;
        if ({m0_rd_data, m1_rd_data} !== {16'h0000, 16'hC0DE}) begin
            bad++; $display("FAIL rm_rd_data got=%h exp=%h", {m0_rd_data, m1_rd_data}, {16'h0000, 16'hC0DE});
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_write;
        test_tie;
        test_read;
        test_both_req;
        test_timeout;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logic_bus_arb.md
LOGIC_BUS_ARB -- requirements
Module: logic_bus_arb

Interface
REQ-001 Parameter P_TIMEOUT_CNT_MAX, default 1000, BUSY cycles before a stalled transaction is aborted.
REQ-002 clk  in  1  clock; all state on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 m0_adr/m1_adr  in  12  master address.
REQ-005 m0_wr_data/m1_wr_data  in  16  master write data.
REQ-006 m0_wr_req/m1_wr_req, m0_rd_req/m1_rd_req  in  1  master write/read request.
REQ-007 m0_ack/m1_ack  out  1  per-master acknowledge.
REQ-008 m0_rd_data/m1_rd_data  out  16  per-master read data, registered.
REQ-009 s_adr  out  12, s_wr_data  out  16, s_wr_req/s_rd_req  out  1  shared logic bus, registered.
REQ-010 s_ack  in  1, s_rd_data  in  16  shared bus acknowledge and read data.
REQ-011 owner  out  1  index of current or last granted master.
REQ-012 err_timeout  out  1  one-cycle pulse on aborted transaction.
REQ-013 err_cnt  out  8  saturating count of timeouts.

Function
REQ-014 Handshake on every port is four-phase: req high with adr/data stable -> ack high -> req low -> ack low; transaction completes on ack falling edge.
REQ-015 A master is requesting when wr_req or rd_req is high; if both are high, the request is a write and rd_req is ignored.
REQ-016 FSM states: S_IDLE, S_BUSY; any other encoding returns to S_IDLE.
REQ-017 S_IDLE: s_wr_req=s_rd_req=0; if exactly one master requests, grant it; if both, grant the master not equal to owner (round-robin); if none, stay.
REQ-018 On grant: owner, s_adr, s_wr_data latched from the granted master at the same edge; state -> S_BUSY; s_wr_req or s_rd_req high in the cycle after the request is first sampled (1-cycle latency).
REQ-019 S_BUSY: s_wr_req/s_rd_req each clock mirror the granted master's wr_req/rd_req (registered, 1-cycle lag); s_adr/s_wr_data hold the latched values.
REQ-020 mX_ack = s_ack AND (state==S_BUSY) AND (owner==X), combinational; the non-granted master's ack stays 0.
REQ-021 mX_rd_data loads s_rd_data on every cycle s_ack is high during a granted read by master X; otherwise it holds.
REQ-022 S_BUSY -> S_IDLE on the cycle after s_ack is sampled high then low (falling edge, registered detector); S_IDLE lasts at least one cycle between grants.
REQ-023 Timeout counter: cleared in S_IDLE, increments each S_BUSY cycle; at P_TIMEOUT_CNT_MAX it forces s_wr_req=s_rd_req=0, pulses err_timeout for 1 cycle, increments err_cnt (saturating at 255), and returns to S_IDLE.
REQ-024 After a timeout, owner keeps the aborted master, so a simultaneous request is granted to the other master first.
REQ-025 A master request dropped before s_ack is seen in S_BUSY causes s_*_req to drop one cycle later; the arbiter stays in S_BUSY until s_ack falls or the timeout fires.
REQ-026 A request arriving during S_BUSY is held off; the arbiter never preempts an active grant.

Reset
REQ-027 rst (synchronous) forces state S_IDLE, owner=1 (so m0 wins the first tie), s_adr=0, s_wr_data=0, s_wr_req=0, s_rd_req=0, m0_rd_data=m1_rd_data=0, err_timeout=0, err_cnt=0, timeout counter=0.
REQ-028 rst asserted mid-transaction aborts it without an err_timeout pulse; m0_ack/m1_ack are 0 in the following cycle.

Verification
REQ-029 m0 write adr=0x123, data=0xBEEF, slave acks after 3 cycles -> s_wr_req high 1 cycle after m0_wr_req; s_adr=0x123; m0_ack mirrors s_ack; return to S_IDLE after s_ack falls.
REQ-030 m0 and m1 raise requests in the same cycle after reset -> m0 granted first, m1 granted after m0 completes; owner sequence 0,1.
REQ-031 m1 read adr=0x010, slave returns 0x5A5A -> m1_rd_data=0x5A5A; m0_rd_data unchanged; m0_ack stays 0.
REQ-032 Slave never acks, P_TIMEOUT_CNT_MAX=1000 -> s_rd_req drops and err_timeout pulses once at BUSY cycle 1000; err_cnt=1; other pending master is granted next.
REQ-033 rst pulsed while in S_BUSY with s_ack high -> all outputs return to reset values next cycle, err_cnt=0; a fresh m1 request is then serviced normally.
REQ-034 Both m0_wr_req and m0_rd_req high -> s_wr_req asserted, s_rd_req stays 0.
